// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared widths, state and port encodings for the memory controller
package mem_ctrl_pkg;

    localparam int MEM_ADDR_BUS = 32;
    localparam int REG_BUS      = 32;
    localparam int INST_BUS     = 32;

    typedef enum logic [1:0] {
        MC_IDLE   = 2'd0,
        MC_ACCESS = 2'd1,
        MC_LAST   = 2'd2,
        MC_DONE   = 2'd3
    } mc_state_e;

    typedef enum logic {
        MC_PORT_IF  = 1'b0,
        MC_PORT_MEM = 1'b1
    } mc_port_e;

    function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] k);
        logic [31:0] shifted;
        shifted = word >> {k, 3'b000};
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - arbitrates fetch and data ports onto a byte-wide synchronous RAM
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int RAM_AW = 17
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_re,
    input  logic [MEM_ADDR_BUS-1:0] if_addr,
    output logic [INST_BUS-1:0]     if_data,
    output logic                    if_done,
    input  logic                    mem_re,
    input  logic                    mem_we,
    input  logic [MEM_ADDR_BUS-1:0] mem_addr,
    input  logic [REG_BUS-1:0]      mem_wdata,
    input  logic [3:0]              mem_sel,
    output logic [REG_BUS-1:0]      mem_rdata,
    output logic                    mem_done,
    output logic                    busy,
    output logic [RAM_AW-1:0]       ram_addr,
    output logic                    ram_we,
    output logic [7:0]              ram_wdata,
    input  logic [7:0]              ram_rdata
);

    mc_state_e             state_q, state_d;
    mc_port_e              port_q, port_d;
    logic                  we_q, we_d;
    logic [RAM_AW-1:0]     base_q, base_d;
    logic [REG_BUS-1:0]    wdata_q, wdata_d;
    logic [3:0]            sel_q, sel_d;
    logic [1:0]            k_q, k_d;
    logic [31:0]           asm_q, asm_d;
    logic [INST_BUS-1:0]   if_data_q, if_data_d;
    logic [REG_BUS-1:0]    mem_rdata_q, mem_rdata_d;

    logic                  unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[MEM_ADDR_BUS-1:RAM_AW], mem_addr[MEM_ADDR_BUS-1:RAM_AW]};

    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        we_d        = we_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        sel_d       = sel_q;
        k_d         = k_q;
        asm_d       = asm_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        ram_addr    = '0;
        ram_we      = 1'b0;
        ram_wdata   = 8'h00;
        busy        = 1'b0;
        if_done     = 1'b0;
        mem_done    = 1'b0;

        case (state_q)
            MC_IDLE: begin
                if (mem_we || mem_re) begin
                    port_d  = MC_PORT_MEM;
                    we_d    = mem_we;
                    base_d  = mem_addr[RAM_AW-1:0];
                    wdata_d = mem_wdata;
                    sel_d   = mem_sel;
                    k_d     = 2'd0;
                    state_d = MC_ACCESS;
                end else if (if_re) begin
                    port_d  = MC_PORT_IF;
                    we_d    = 1'b0;
                    base_d  = if_addr[RAM_AW-1:0];
                    wdata_d = '0;
                    sel_d   = 4'h0;
                    k_d     = 2'd0;
                    state_d = MC_ACCESS;
                end
            end
            MC_ACCESS: begin
                busy     = 1'b1;
                ram_addr = base_q + RAM_AW'(k_q);
                if (we_q) begin
                    // A reset arriving mid-write must not let the current byte land.
                    ram_we    = sel_q[k_q] & rst;
                    ram_wdata = byte_of(wdata_q, k_q);
                end else if (k_q != 2'd0) begin
                    asm_d = {ram_rdata, asm_q[31:8]};
                end
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d = we_q ? MC_DONE : MC_LAST;
                end
            end
            MC_LAST: begin
                busy = 1'b1;
                if (port_q == MC_PORT_IF) begin
                    if_data_d = {ram_rdata, asm_q[31:8]};
                end else begin
                    mem_rdata_d = {ram_rdata, asm_q[31:8]};
                end
                state_d = MC_DONE;
            end
            MC_DONE: begin
                if_done  = (port_q == MC_PORT_IF);
                mem_done = (port_q == MC_PORT_MEM);
                state_d  = MC_IDLE;
            end
            default: state_d = MC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= MC_IDLE;
            port_q      <= MC_PORT_IF;
            we_q        <= 1'b0;
            base_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= 4'h0;
            k_q         <= 2'd0;
            asm_q       <= '0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            we_q        <= we_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            sel_q       <= sel_d;
            k_q         <= k_d;
            asm_q       <= asm_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign if_data   = if_data_q;
    assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - randomized self-checking bench for mem_ctrl against a byte-array model
module tb_mem_ctrl;

    localparam int AW  = 17;
    localparam int RSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_re;
    logic [31:0]   if_addr;
    logic [31:0]   if_data;
    logic          if_done;
    logic          mem_re;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_sel;
    logic [31:0]   mem_rdata;
    logic          mem_done;
    logic          busy;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;

    logic [7:0]    ram [RSZ];
    logic [7:0]    ref_mem [RSZ];
    logic [31:0]   exp_if_data;
    logic [31:0]   exp_mem_rdata;
    int            n_checks = 0;
    int            n_errors = 0;

    always #5 clk = ~clk;

    mem_ctrl #(.RAM_AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_re     (if_re),
        .if_addr   (if_addr),
        .if_data   (if_data),
        .if_done   (if_done),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_sel   (mem_sel),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .busy      (busy),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Synchronous byte RAM: read data appears the cycle after its address.
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] = ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_word(input logic [AW-1:0] base);
        logic [31:0]   w;
        logic [AW-1:0] a;
        for (int i = 0; i < 4; i++) begin
            a = base + AW'(i);
            w[8*i +: 8] = ref_mem[a];
        end
        return w;
    endfunction

    task automatic req_mem(input bit re, input bit we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] sel);
        mem_re    = re;
        mem_we    = we;
        mem_addr  = a;
        mem_wdata = wd;
        mem_sel   = sel;
    endtask

    // Called in the accept cycle; walks the whole transaction and ends in its done cycle.
    task automatic expect_op(input bit to_if, input bit we, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] sel);
        int            lat;
        logic [AW-1:0] base;
        logic [AW-1:0] a;
        logic [31:0]   word;
        lat  = we ? 5 : 6;
        base = addr[AW-1:0];
        word = ref_word(base);
        for (int c = 1; c <= lat; c++) begin
            step();
            check_eq("busy", busy, (c < lat) ? 32'd1 : 32'd0);
            if (c <= 4) begin
                a = base + AW'(c - 1);
                check_eq("ram_addr", ram_addr, a);
                check_eq("ram_we", ram_we, we & sel[c-1]);
                if (we && sel[c-1]) begin
                    check_eq("ram_wdata", ram_wdata, wd[8*(c-1) +: 8]);
                    ref_mem[a] = wd[8*(c-1) +: 8];
                end
            end else begin
                check_eq("ram_we_tail", ram_we, 0);
            end
            check_eq("if_done", if_done, (c == lat) && to_if);
            check_eq("mem_done", mem_done, (c == lat) && !to_if);
            if (c == lat) begin
                if (!we) begin
                    if (to_if) exp_if_data = word;
                    else       exp_mem_rdata = word;
                end
                check_eq("if_data", if_data, exp_if_data);
                check_eq("mem_rdata", mem_rdata, exp_mem_rdata);
                if (to_if) if_re = 1'b0;
                else begin
                    mem_re = 1'b0;
                    mem_we = 1'b0;
                end
            end
        end
    endtask

    initial begin
        logic [7:0]  o1, o3;
        logic [31:0] a_if, a_mem, wd;
        logic [3:0]  sel;
        int          kind, mism;
        bit          also_if;

        for (int i = 0; i < RSZ; i++) begin
            ram[i]     = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        rst = 1'b0;
        if_re = 1'b0;
        if_addr = '0;
        req_mem(0, 0, 0, 0, 0);
        exp_if_data = '0;
        exp_mem_rdata = '0;
        step();
        step();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_if_done", if_done, 0);
        check_eq("rst_mem_done", mem_done, 0);
        check_eq("rst_if_data", if_data, 0);
        check_eq("rst_mem_rdata", mem_rdata, 0);
        check_eq("rst_ram_we", ram_we, 0);
        check_eq("rst_ram_addr", ram_addr, 0);
        check_eq("rst_ram_wdata", ram_wdata, 0);
        rst = 1'b1;
        step();

        // Instruction fetch of a preloaded word
        ram[17'h100] = 8'h78; ram[17'h101] = 8'h56; ram[17'h102] = 8'h34; ram[17'h103] = 8'h12;
        for (int i = 0; i < 4; i++) ref_mem[17'h100 + i] = ram[17'h100 + i];
        if_re = 1'b1;
        if_addr = 32'h100;
        expect_op(1, 0, 32'h100, 0, 0);
        check_eq("tp1_if_data", if_data, 32'h12345678);
        step();

        // Partial-select write
        o1 = ram[17'h201];
        o3 = ram[17'h203];
        req_mem(0, 1, 32'h200, 32'hAABBCCDD, 4'b0101);
        expect_op(0, 1, 32'h200, 32'hAABBCCDD, 4'b0101);
        step();
        check_eq("tp2_b0", ram[17'h200], 8'hDD);
        check_eq("tp2_b1", ram[17'h201], o1);
        check_eq("tp2_b2", ram[17'h202], 8'hBB);
        check_eq("tp2_b3", ram[17'h203], o3);

        // Simultaneous requests: data port first, fetch accepted the cycle after DONE
        if_re = 1'b1;
        if_addr = 32'h0000_0140;
        req_mem(1, 0, 32'h0000_0180, 0, 0);
        expect_op(0, 0, 32'h180, 0, 0);
        step();
        check_eq("tp3_accept_busy", busy, 0);
        check_eq("tp3_accept_if_done", if_done, 0);
        expect_op(1, 0, 32'h140, 0, 0);
        step();

        // Wrap at the top of the RAM
        if_re = 1'b1;
        if_addr = 32'hABC3_FFFE;
        expect_op(1, 0, 32'hABC3_FFFE, 0, 0);
        step();

        // Reset during the third access cycle of a write
        wd = $urandom;
        o1 = ref_mem[17'h302];
        o3 = ref_mem[17'h303];
        req_mem(0, 1, 32'h300, wd, 4'hF);
        step();
        step();
        step();
        rst = 1'b0;
        #1;
        check_eq("tp5_we_in_reset", ram_we, 0);
        step();
        check_eq("tp5_busy", busy, 0);
        check_eq("tp5_ram_we", ram_we, 0);
        check_eq("tp5_mem_done", mem_done, 0);
        check_eq("tp5_mem_rdata", mem_rdata, 0);
        rst = 1'b1;
        req_mem(0, 0, 0, 0, 0);
        ref_mem[17'h300] = wd[7:0];
        ref_mem[17'h301] = wd[15:8];
        exp_if_data = '0;
        exp_mem_rdata = '0;
        step();
        step();
        check_eq("tp5_b2", ram[17'h302], o1);
        check_eq("tp5_b3", ram[17'h303], o3);

        // Combined re/we after a read leaves mem_rdata alone
        req_mem(1, 0, 32'h100, 0, 0);
        expect_op(0, 0, 32'h100, 0, 0);
        step();
        wd = $urandom;
        req_mem(1, 1, 32'h104, wd, 4'hF);
        expect_op(0, 1, 32'h104, wd, 4'hF);
        check_eq("tp6_mem_rdata", mem_rdata, 32'h12345678);
        step();

        // Randomized mix, including contention and zero-select writes
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 3);
            a_mem = $urandom;
            a_if  = $urandom;
            if ($urandom_range(0, 3) == 0) a_mem[AW-1:0] = 17'h1FFFC + 17'($urandom_range(0, 3));
            else                           a_mem[AW-1:0] = 17'h400 + 17'($urandom_range(0, 63));
            a_if[AW-1:0] = 17'h400 + 17'($urandom_range(0, 63));
            wd  = $urandom;
            sel = 4'($urandom);
            if (n % 8 == 0) sel = 4'h0;
            if (kind == 0) begin
                if_re = 1'b1;
                if_addr = a_mem;
                expect_op(1, 0, a_mem, 0, 0);
            end else begin
                also_if = ($urandom_range(0, 1) == 1);
                if (also_if) begin
                    if_re = 1'b1;
                    if_addr = a_if;
                end
                req_mem(kind != 2, kind != 1, a_mem, wd, sel);
                expect_op(0, kind != 1, a_mem, wd, sel);
                if (also_if) begin
                    step();
                    expect_op(1, 0, a_if, 0, 0);
                end
            end
            step();
        end

        mism = 0;
        for (int i = 0; i < RSZ; i++) if (ram[i] !== ref_mem[i]) mism++;
        check_eq("ram_image", mism, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
